// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Used by dmem_arb_pick and dmem_arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lk_state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  localparam int LOCK_TIMEOUT_DEF = 16;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-way winner selection: lock owner first, then round-robin
// (or port 0 on a tie when DMEM_ARB_FIXED_PRIO_EN is defined).
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
  input  lk_state_t lk_state,
  input  logic      rr_last,
  output logic      gnt_vld,
  output logic      gnt_port
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = PORT_CORE;
    case (lk_state)
      LOCKED0: begin
        gnt_vld  = req0;
        gnt_port = PORT_CORE;
      end
      LOCKED1: begin
        gnt_vld  = req1;
        gnt_port = PORT_DMA;
      end
      default: begin
        gnt_vld = req0 | req1;
        if (req0 && req1) begin
          gnt_port = FIXED_PRIO ? PORT_CORE : ~rr_last;
        end else begin
          gnt_port = req1 ? PORT_DMA : PORT_CORE;
        end
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory (port 0 = core LSU, port 1 = DMA/debug).
// Optional fixed-priority tie-break via `DMEM_ARB_FIXED_PRIO_EN; lock ownership with idle timeout.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic          p0_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ready,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic          p1_lock,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ready,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);

  lk_state_t     lk_state_q, lk_state_d;
  logic          rr_last_q, rr_last_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

  logic gnt_raw, gnt_vld, gnt_port, gnt_lock;

  dmem_arb_pick u_pick (
    .req0     (p0_req),
    .req1     (p1_req),
    .lk_state (lk_state_q),
    .rr_last  (rr_last_q),
    .gnt_vld  (gnt_raw),
    .gnt_port (gnt_port)
  );

  // NOTE: the grant is masked by reset so no write or ready escapes while the flops are being cleared.
  assign gnt_vld  = gnt_raw & ~reset;
  assign gnt_lock = (gnt_port == PORT_DMA) ? p1_lock : p0_lock;

  always_comb begin
    p0_ready = gnt_vld && (gnt_port == PORT_CORE);
    p1_ready = gnt_vld && (gnt_port == PORT_DMA);
    mem_we   = 1'b0;
    mem_a    = '0;
    mem_wd   = '0;
    if (gnt_vld) begin
      if (gnt_port == PORT_DMA) begin
        mem_we = p1_we;
        mem_a  = p1_addr;
        mem_wd = p1_wdata;
      end else begin
        mem_we = p0_we;
        mem_a  = p0_addr;
        mem_wd = p0_wdata;
      end
    end
  end

  always_comb begin
    lk_state_d  = lk_state_q;
    rr_last_d   = rr_last_q;
    to_cnt_d    = to_cnt_q;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    if (gnt_vld) begin
      rr_last_d = gnt_port;
      to_cnt_d  = '0;
      if (gnt_lock) begin
        lk_state_d = (gnt_port == PORT_DMA) ? LOCKED1 : LOCKED0;
      end else begin
        lk_state_d = UNLOCKED;
      end
      if (!mem_we) begin
        if (gnt_port == PORT_DMA) begin
          p1_rdata_d  = mem_rd;
          p1_rvalid_d = 1'b1;
        end else begin
          p0_rdata_d  = mem_rd;
          p0_rvalid_d = 1'b1;
        end
      end
    end else if (lk_state_q != UNLOCKED) begin
      // Owner idle this cycle: count toward the forced release.
      if (to_cnt_q == TO_LAST) begin
        lk_state_d = UNLOCKED;
        to_cnt_d   = '0;
      end else begin
        to_cnt_d = to_cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the combinational blocks above use blocking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lk_state_q  <= UNLOCKED;
      rr_last_q   <= PORT_DMA;
      to_cnt_q    <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      lk_state_q  <= lk_state_d;
      rr_last_q   <= rr_last_d;
      to_cnt_q    <= to_cnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule
